// File: rtl/hud_number_renderer.sv
`default_nettype none
// ============================================================================
// Module      : hud_number_renderer
// Description : Renders N_FIELDS decimal numbers into a pixel write port.
//               Each field value is converted to BCD (shift-add-3), then each
//               digit glyph is scanned out of an external glyph ROM row-major
//               and written as fg/bg coloured pixels, with optional
//               leading-zero blanking and saturation to all nines.
// Revision    : 1.0 - initial release
// ============================================================================
module hud_number_renderer #(
    parameter int N_FIELDS    = 2,
    parameter int DIGITS      = 3,
    parameter int VAL_W       = 8,
    parameter int GLYPH_W     = 4,
    parameter int GLYPH_H     = 8,
    parameter int DIGIT_PITCH = 5,
    localparam int ROM_AW     = $clog2(10 * GLYPH_W * GLYPH_H)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [N_FIELDS*VAL_W-1:0] values,
    input  logic [N_FIELDS*9-1:0]     field_x,
    input  logic [N_FIELDS*8-1:0]     field_y,
    input  logic                      blank_lz,
    input  logic [11:0]               fg_color,
    input  logic [11:0]               bg_color,
    output logic [ROM_AW-1:0]         rom_addr,
    input  logic                      rom_data,
    output logic [8:0]                outX,
    output logic [7:0]                outY,
    output logic [11:0]               color,
    output logic                      writeEn,
    output logic                      busy,
    output logic                      done
);

    // Largest value representable in DIGITS decimal digits.
    function automatic longint unsigned f_max_val(input int n);
        longint unsigned m;
        m = 1;
        for (int i = 0; i < n; i++) begin
            m = m * 10;
        end
        return m - 1;
    endfunction

    localparam int              c_PIX   = GLYPH_W * GLYPH_H;
    localparam int              c_ROW_W = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam int              c_COL_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int              c_BIT_W = $clog2(VAL_W + 1);
    localparam int              c_DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int              c_FLD_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
    localparam int              c_BCD_W = 4 * DIGITS;
    localparam longint unsigned c_MAX   = f_max_val(DIGITS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_CONVERT   = 3'd2,
        S_DIG_SETUP = 3'd3,
        S_DRAW      = 3'd4,
        S_FLUSH     = 3'd5,
        S_NEXT      = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    // Snapshot of the frame inputs; shifted down one field at a time so the
    // current field always sits in the low slice.
    logic [N_FIELDS*VAL_W-1:0] r_values;
    logic [N_FIELDS*9-1:0]     r_fx;
    logic [N_FIELDS*8-1:0]     r_fy;
    logic                      r_blank_lz;

    logic [VAL_W-1:0]          r_bin;
    logic [c_BCD_W-1:0]        r_bcd;
    logic                      r_sat;
    logic [c_BIT_W-1:0]        r_bitcnt;
    logic [c_FLD_W-1:0]        r_field;
    logic [c_DIG_W-1:0]        r_dig;
    logic [c_ROW_W-1:0]        r_row;
    logic [c_COL_W-1:0]        r_col;
    logic [3:0]                r_glyph;
    logic                      r_blank_dig;
    logic                      r_lz_active;

    logic [8:0]                r_out_x;
    logic [7:0]                r_out_y;
    logic                      r_we;
    logic                      r_blank_q;
    logic                      r_busy;
    logic                      r_done;

    logic [c_BCD_W-1:0]        w_bcd_adj;
    logic [3:0]                w_glyph;
    logic                      w_last_pix;
    logic [8:0]                w_org_x;

    // Add-3 correction of every BCD nibble ahead of the next shift.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_bcd_adj
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                          (r_bcd[gi*4 +: 4] + 4'd3) :
                                           r_bcd[gi*4 +: 4];
        end
    endgenerate

    // The digit being set up is always the top nibble; saturation forces 9.
    assign w_glyph    = r_sat ? 4'd9 : r_bcd[c_BCD_W-1 -: 4];
    assign w_last_pix = (r_row == c_ROW_W'(GLYPH_H - 1)) &&
                        (r_col == c_COL_W'(GLYPH_W - 1));
    assign w_org_x    = r_fx[8:0] + 9'(32'(r_dig) * DIGIT_PITCH);

    assign rom_addr = ROM_AW'(32'(r_glyph) * c_PIX + 32'(r_row) * GLYPH_W + 32'(r_col));
    assign outX     = r_out_x;
    assign outY     = r_out_y;
    assign writeEn  = r_we;
    assign busy     = r_busy;
    assign done     = r_done;
    // ROM data arrives together with the delayed write, so colour is resolved here.
    assign color    = r_we ? ((rom_data && !r_blank_q) ? fg_color : bg_color) : 12'd0;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (start) w_state_nxt = S_LOAD;
            S_LOAD:      w_state_nxt = S_CONVERT;
            S_CONVERT:   if (r_bitcnt == c_BIT_W'(VAL_W - 1)) w_state_nxt = S_DIG_SETUP;
            S_DIG_SETUP: w_state_nxt = S_DRAW;
            S_DRAW:      if (w_last_pix) w_state_nxt = S_FLUSH;
            S_FLUSH:     w_state_nxt = (r_dig == c_DIG_W'(DIGITS - 1)) ? S_NEXT : S_DIG_SETUP;
            S_NEXT:      w_state_nxt = (r_field == c_FLD_W'(N_FIELDS - 1)) ? S_DONE : S_LOAD;
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: snapshot, BCD conversion, digit/pixel counters, busy/done.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_values    <= '0;
            r_fx        <= '0;
            r_fy        <= '0;
            r_blank_lz  <= 1'b0;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_sat       <= 1'b0;
            r_bitcnt    <= '0;
            r_field     <= '0;
            r_dig       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_glyph     <= 4'd0;
            r_blank_dig <= 1'b0;
            r_lz_active <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_values   <= values;
                        r_fx       <= field_x;
                        r_fy       <= field_y;
                        r_blank_lz <= blank_lz;
                        r_field    <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_bin       <= r_values[VAL_W-1:0];
                    r_bcd       <= '0;
                    r_bitcnt    <= '0;
                    r_sat       <= (64'(r_values[VAL_W-1:0]) > c_MAX);
                    r_lz_active <= 1'b1;
                    r_dig       <= '0;
                end
                S_CONVERT: begin
                    r_bcd    <= {w_bcd_adj[c_BCD_W-2:0], r_bin[VAL_W-1]};
                    r_bin    <= r_bin << 1;
                    r_bitcnt <= r_bitcnt + 1'b1;
                end
                S_DIG_SETUP: begin
                    r_glyph     <= w_glyph;
                    r_blank_dig <= r_blank_lz && r_lz_active && (w_glyph == 4'd0) &&
                                   (r_dig != c_DIG_W'(DIGITS - 1));
                    if (w_glyph != 4'd0) begin
                        r_lz_active <= 1'b0;
                    end
                    r_row <= '0;
                    r_col <= '0;
                end
                S_DRAW: begin
                    if (r_col == c_COL_W'(GLYPH_W - 1)) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_bcd <= r_bcd << 4;
                    if (r_dig != c_DIG_W'(DIGITS - 1)) begin
                        r_dig <= r_dig + 1'b1;
                    end
                end
                S_NEXT: begin
                    r_values <= r_values >> VAL_W;
                    r_fx     <= r_fx >> 9;
                    r_fy     <= r_fy >> 8;
                    r_field  <= r_field + 1'b1;
                end
                S_DONE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    // Pixel write pipeline: coordinates lag the ROM address by one cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_we      <= 1'b0;
            r_out_x   <= 9'd0;
            r_out_y   <= 8'd0;
            r_blank_q <= 1'b0;
        end else begin
            r_we <= (r_state == S_DRAW);
            if (r_state == S_DRAW) begin
                r_out_x   <= w_org_x + 9'(r_col);
                r_out_y   <= r_fy[7:0] + 8'(r_row);
                r_blank_q <= r_blank_dig;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hud_number_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hud_number_renderer
// Description : Scoreboard bench for hud_number_renderer. Two instances: the
//               default configuration and a 1-field 2-digit variant used for
//               saturation. Expected pixels are queued when a frame starts
//               and popped on every writeEn.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hud_number_renderer;

    localparam logic [11:0] FG = 12'hF0F;
    localparam logic [11:0] BG = 12'h123;

    typedef struct packed {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [11:0] c;
    } px_t;

    logic        clk;
    logic        resetn;
    logic [11:0] fg_color, bg_color;

    // Default instance signals
    logic        start, blank_lz, rom_data, writeEn, busy, done;
    logic [15:0] values;
    logic [17:0] field_x;
    logic [15:0] field_y;
    logic [8:0]  rom_addr;
    logic [8:0]  outX;
    logic [7:0]  outY;
    logic [11:0] color;

    // Two-digit single-field instance signals
    logic        start2, blank_lz2, rom_data2, writeEn2, busy2, done2;
    logic [7:0]  values2;
    logic [8:0]  field_x2;
    logic [7:0]  field_y2;
    logic [8:0]  rom_addr2;
    logic [8:0]  outX2;
    logic [7:0]  outY2;
    logic [11:0] color2;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  n_wr1, n_wr2, n_done1, n_done2;
    px_t q1[$];
    px_t q2[$];
    px_t p1, p2;

    hud_number_renderer u_dut (
        .clk(clk), .resetn(resetn), .start(start), .values(values),
        .field_x(field_x), .field_y(field_y), .blank_lz(blank_lz),
        .fg_color(fg_color), .bg_color(bg_color), .rom_addr(rom_addr),
        .rom_data(rom_data), .outX(outX), .outY(outY), .color(color),
        .writeEn(writeEn), .busy(busy), .done(done)
    );

    hud_number_renderer #(.N_FIELDS(1), .DIGITS(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .start(start2), .values(values2),
        .field_x(field_x2), .field_y(field_y2), .blank_lz(blank_lz2),
        .fg_color(fg_color), .bg_color(bg_color), .rom_addr(rom_addr2),
        .rom_data(rom_data2), .outX(outX2), .outY(outY2), .color(color2),
        .writeEn(writeEn2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Glyph ROM content: arbitrary but fixed pattern, so every digit differs.
    function automatic logic rom_bit(input int a);
        return ((a * 5 + a / 3) % 7) < 3;
    endfunction

    // Synchronous glyph ROMs: data one cycle after address.
    always @(posedge clk) begin
        rom_data  <= rom_bit(int'(rom_addr));
        rom_data2 <= rom_bit(int'(rom_addr2));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pixel monitors: pop the scoreboard on every write.
    always @(negedge clk) begin
        if (writeEn === 1'b1) begin
            n_wr1++;
            if (q1.size() == 0) begin
                check("dut1 pixel queue", 32'(q1.size()), 32'd1);
            end else begin
                p1 = q1.pop_front();
                check("dut1 pixel", 32'({outX, outY, color}), 32'(p1));
            end
        end
        if (done === 1'b1) n_done1++;
    end

    always @(negedge clk) begin
        if (writeEn2 === 1'b1) begin
            n_wr2++;
            if (q2.size() == 0) begin
                check("dut2 pixel queue", 32'(q2.size()), 32'd1);
            end else begin
                p2 = q2.pop_front();
                check("dut2 pixel", 32'({outX2, outY2, color2}), 32'(p2));
            end
        end
        if (done2 === 1'b1) n_done2++;
    end

    // Reference model: decimal digits by division, MSD first, row-major scan.
    task automatic push_frame(input int which, input int nf, input int nd,
                              input logic [15:0] vals, input logic [17:0] fx,
                              input logic [15:0] fy, input bit blz);
        for (int f = 0; f < nf; f++) begin
            int v, vmax, pw, dig, x0, y0;
            bit lz, blank;
            px_t p;
            v    = int'(vals[f*8 +: 8]);
            vmax = 10 ** nd - 1;
            if (v > vmax) v = vmax;
            lz = 1'b1;
            for (int d = 0; d < nd; d++) begin
                pw = 1;
                for (int k = 0; k < nd - 1 - d; k++) pw = pw * 10;
                dig   = (v / pw) % 10;
                blank = blz && lz && (dig == 0) && (d != nd - 1);
                if (dig != 0) lz = 1'b0;
                x0 = int'(fx[f*9 +: 9]) + d * 5;
                y0 = int'(fy[f*8 +: 8]);
                for (int r = 0; r < 8; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        p.x = 9'(x0 + c);
                        p.y = 8'(y0 + r);
                        p.c = (!blank && rom_bit(dig * 32 + r * 4 + c)) ? FG : BG;
                        if (which == 0) q1.push_back(p);
                        else            q2.push_back(p);
                    end
                end
            end
        end
    endtask

    task automatic start_frame(input int which, input logic [15:0] vals,
                               input logic [17:0] fx, input logic [15:0] fy,
                               input bit blz, output int c0);
        if (which == 0) push_frame(0, 2, 3, vals, fx, fy, blz);
        else            push_frame(1, 1, 2, vals, fx, fy, blz);
        @(posedge clk);
        #1;
        if (which == 0) begin
            values = vals; field_x = fx; field_y = fy; blank_lz = blz;
            start = 1'b1; n_wr1 = 0; n_done1 = 0;
        end else begin
            values2 = vals[7:0]; field_x2 = fx[8:0]; field_y2 = fy[7:0]; blank_lz2 = blz;
            start2 = 1'b1; n_wr2 = 0; n_done2 = 0;
        end
        @(posedge clk);
        #1;
        c0     = cyc;
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic finish_frame(input int which, input int c0, input string tag);
        int lat, nwr;
        lat = (which == 0) ? 225 : 79;
        nwr = (which == 0) ? 192 : 64;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 0) check({tag, " busy in frame"}, 32'(which ? busy2 : busy), 32'd1);
            if ((which ? done2 : done) === 1'b1) break;
        end
        check({tag, " done latency"}, 32'(cyc - c0), 32'(lat));
        check({tag, " busy at done"}, 32'(which ? busy2 : busy), 32'd0);
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(which ? done2 : done), 32'd0);
        check({tag, " write count"}, 32'(which ? n_wr2 : n_wr1), 32'(nwr));
        check({tag, " queue drained"}, 32'(which ? q2.size() : q1.size()), 32'd0);
    endtask

    initial begin
        int c0;
        resetn = 1'b0; start = 1'b0; start2 = 1'b0;
        values = '0; field_x = '0; field_y = '0; blank_lz = 1'b0;
        values2 = '0; field_x2 = '0; field_y2 = '0; blank_lz2 = 1'b0;
        fg_color = FG; bg_color = BG;
        n_wr1 = 0; n_wr2 = 0; n_done1 = 0; n_done2 = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset writeEn", 32'(writeEn), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset outXY", 32'({outX, outY}), 32'd0);
        check("reset color", 32'(color), 32'd0);
        check("reset rom_addr", 32'(rom_addr), 32'd0);
        check("reset dut2 writeEn", 32'(writeEn2), 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // "042" and "200", second field wraps in x and y
        start_frame(0, {8'hC8, 8'h2A}, {9'd505, 9'd10}, {8'd252, 8'd20}, 1'b0, c0);
        finish_frame(0, c0, "frame 042/200");

        // Blanking: 5 -> two blank digits then "5"; 0 -> single "0"
        start_frame(0, {8'h00, 8'h05}, {9'd40, 9'd30}, {8'd60, 8'd5}, 1'b1, c0);
        finish_frame(0, c0, "blank 5/0");

        // Blanking: 10 -> blank,"1","0"; 100 keeps its inner zeros
        start_frame(0, {8'h64, 8'h0A}, {9'd0, 9'd200}, {8'd0, 8'd100}, 1'b1, c0);
        finish_frame(0, c0, "blank 10/100");

        // Inputs change after acceptance and a second start arrives mid-frame
        start_frame(0, {8'hFF, 8'h11}, {9'd300, 9'd7}, {8'd9, 8'd70}, 1'b0, c0);
        values = 16'h3322; field_x = 18'd0; field_y = 16'd0; blank_lz = 1'b1;
        repeat (49) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_frame(0, c0, "snapshot/restart");
        repeat (300) @(negedge clk);
        check("restart ignored done count", 32'(n_done1), 32'd1);
        check("restart ignored writes", 32'(n_wr1), 32'd192);

        // Reset in the middle of a DRAW phase
        start_frame(0, {8'h7B, 8'hEA}, {9'd60, 9'd80}, {8'd40, 8'd50}, 1'b0, c0);
        repeat (99) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset writeEn", 32'(writeEn), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset rom_addr", 32'(rom_addr), 32'd0);
        check("midreset outXY", 32'({outX, outY}), 32'd0);
        q1.delete();
        @(posedge clk);
        #1 resetn = 1'b1;
        start_frame(0, {8'h99, 8'h01}, {9'd12, 9'd34}, {8'd56, 8'd78}, 1'b1, c0);
        finish_frame(0, c0, "after reset");

        // Two-digit instance: saturation and its boundary
        start_frame(1, 16'h00FF, 18'd100, 16'd10, 1'b0, c0);
        finish_frame(1, c0, "dut2 255");
        start_frame(1, 16'h0064, 18'd510, 16'd255, 1'b1, c0);
        finish_frame(1, c0, "dut2 100");
        start_frame(1, 16'h0063, 18'd20, 16'd30, 1'b1, c0);
        finish_frame(1, c0, "dut2 99");
        start_frame(1, 16'h0009, 18'd20, 16'd30, 1'b1, c0);
        finish_frame(1, c0, "dut2 9");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
